mem_port_arbiter: RTL and testbench

Shares the single-ported unified memory between the pipelined CPU's instruction-fetch (IF) and data (MEM) stages. It arbitrates requests, drives the memory port, counts fixed memory latency, and routes the response back to the winning requester. It sits between the IF/MEM stage logic and the memory model. It allows one transaction in flight at a time.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_lat_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the IF/MEM memory port arbiter:
//   - arb_state_e : arbiter FSM states (IDLE / ISSUE / WAIT)
//   - owner_e     : which requester owns the in-flight access
//   - SZ_*        : access size codes driven on mem_size
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter
//   Loadable down-counter that times the fixed memory latency.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset (count -> 0)
//     load : load the count with MEM_LAT
//     dec  : decrement by one (saturates at 0, never wraps)
//     last : count == 1, i.e. the current cycle is the response cycle
module arb_lat_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CNT_W'(MEM_LAT);
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the CPU fetch (IF) and data
//   (MEM) stages. One access in flight; fixed latency MEM_LAT.
//   Build option: define ARB_ROUND_ROBIN_EN to alternate the winner on
//   simultaneous requests (otherwise data always beats fetch).
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     halt                     : blocks new grants (in-flight access completes)
//     if_req/if_addr           : fetch request and address
//     if_gnt/if_rvalid/if_rdata: fetch accept pulse, data valid pulse, data
//     d_req/d_we/d_size/d_addr/d_wdata : data request and fields
//     d_gnt/d_rvalid/d_rdata   : data accept pulse, done pulse, load data
//     mem_en/mem_we/mem_size/mem_addr/mem_wdata : memory command (ISSUE only)
//     mem_rdata                : memory read data, valid in the response cycle
//     busy                     : arbiter not idle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_reg, state_next;
  owner_e            owner_reg, owner_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        size_reg, size_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;

  owner_e winner;
  logic   can_grant;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_last;

  assign can_grant = !halt && (if_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner_reg;

  // On a tie the port that did not own the previous grant wins.
  always_comb begin
    if (if_req && d_req) begin
      winner = (last_owner_reg == OWN_D) ? OWN_IF : OWN_D;
    end else if (d_req) begin
      winner = OWN_D;
    end else begin
      winner = OWN_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_reg <= OWN_IF;
    end else if (state_reg == ISSUE) begin
      last_owner_reg <= owner_reg;
    end
  end
`else
  // The MEM stage holds the older instruction, so fetch yields.
  always_comb begin
    winner = d_req ? OWN_D : OWN_IF;
  end
`endif

  arb_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_counter (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .dec (cnt_dec),
    .last(cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= OWN_IF;
      addr_reg  <= '0;
      size_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      size_reg  <= size_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    size_next  = size_reg;
    we_next    = we_reg;
    wdata_next = wdata_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    d_gnt      = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_size   = '0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // Capture the winner's fields; shared by IDLE and the response cycle.
    if (can_grant) begin
      owner_next = winner;
      if (winner == OWN_D) begin
        addr_next  = d_addr;
        size_next  = d_size;
        we_next    = d_we;
        wdata_next = d_wdata;
      end else begin
        addr_next  = if_addr;
        size_next  = SZ_W;
        we_next    = 1'b0;
        wdata_next = '0;
      end
    end

    unique case (state_reg)
      IDLE: begin
        if (can_grant) state_next = ISSUE;
      end
      ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = we_reg;
        mem_size   = size_reg;
        mem_addr   = addr_reg;
        mem_wdata  = wdata_reg;
        if_gnt     = (owner_reg == OWN_IF);
        d_gnt      = (owner_reg == OWN_D);
        cnt_load   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          if (owner_reg == OWN_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = we_reg ? '0 : mem_rdata;
          end
          state_next = can_grant ? ISSUE : IDLE;
        end else begin
          // Requests are only sampled in IDLE and the response cycle.
          owner_next = owner_reg;
          addr_next  = addr_reg;
          size_next  = size_reg;
          we_next    = we_reg;
          wdata_next = wdata_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // ISSUE never samples requests.
    if (state_reg == ISSUE) begin
      owner_next = owner_reg;
      addr_next  = addr_reg;
      size_next  = size_reg;
      we_next    = we_reg;
      wdata_next = wdata_reg;
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench: two arbiters (MEM_LAT=1 as "a", MEM_LAT=3 as "b") share
//   the same stimulus; each step checks the instance it targets.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [1:0]  a_mem_size;

  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [1:0]  b_mem_size;

  int n_cmp = 0;
  int n_bad = 0;
  int gnt_seen;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid),
    .d_rdata(a_d_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_size(a_mem_size), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
    .d_rdata(b_d_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_size(b_mem_size), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
    $display("check %-24s got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_mem_en", a_mem_en, 0);
    chk("rst_a_gnts", {a_if_gnt, a_d_gnt}, 0);
    chk("rst_a_mem_addr", a_mem_addr, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_rvalids", {b_if_rvalid, b_d_rvalid}, 0);

    // Single fetch, MEM_LAT=1 (cycle 0 = now)
    if_req = 1'b1; if_addr = 32'h10;
    tick();                                   // cycle 1
    chk("f1_mem_en", a_mem_en, 1);
    chk("f1_if_gnt", a_if_gnt, 1);
    chk("f1_mem_addr", a_mem_addr, 32'h10);
    chk("f1_mem_size", a_mem_size, 2);
    chk("f1_mem_we", a_mem_we, 0);
    if_req = 1'b0; mem_rdata = 32'h13;
    tick();                                   // cycle 2
    chk("f2_if_rvalid", a_if_rvalid, 1);
    chk("f2_if_rdata", a_if_rdata, 32'h13);
    chk("f2_mem_en", a_mem_en, 0);
    tick();                                   // cycle 3
    chk("f3_busy", a_busy, 0);
    chk("f3_if_rvalid", a_if_rvalid, 0);

    // Simultaneous fetch + load after reset (last owner IF): data first
    do_reset();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h100;
    tick();                                   // cycle 1
    chk("s1_d_gnt", a_d_gnt, 1);
    chk("s1_if_gnt", a_if_gnt, 0);
    chk("s1_mem_addr", a_mem_addr, 32'h100);
    d_req = 1'b0; mem_rdata = 32'h55;
    tick();                                   // cycle 2
    chk("s2_d_rvalid", a_d_rvalid, 1);
    chk("s2_d_rdata", a_d_rdata, 32'h55);
    chk("s2_if_rvalid", a_if_rvalid, 0);
    tick();                                   // cycle 3
    chk("s3_if_gnt", a_if_gnt, 1);
    chk("s3_d_gnt", a_d_gnt, 0);
    chk("s3_mem_addr", a_mem_addr, 32'h40);
    if_req = 1'b0; mem_rdata = 32'h66;
    tick();                                   // cycle 4
    chk("s4_if_rvalid", a_if_rvalid, 1);
    chk("s4_if_rdata", a_if_rdata, 32'h66);
    chk("s4_d_rvalid", a_d_rvalid, 0);
    tick();
    chk("s5_busy", a_busy, 0);

    // Tie after a data grant (last owner D)
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h104;
    tick();                                   // cycle 1
    chk("t1_d_gnt", a_d_gnt, 1);
    d_req = 1'b0;
    tick();                                   // cycle 2 (response)
    chk("t2_d_rvalid", a_d_rvalid, 1);
    if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_addr = 32'h108;
    tick();                                   // cycle 3
`ifdef ARB_ROUND_ROBIN_EN
    chk("t3_if_gnt", a_if_gnt, 1);
    chk("t3_d_gnt", a_d_gnt, 0);
    if_req = 1'b0;
`else
    chk("t3_d_gnt", a_d_gnt, 1);
    chk("t3_if_gnt", a_if_gnt, 0);
    chk("t3_mem_addr", a_mem_addr, 32'h108);
    d_req = 1'b0;
`endif
    tick(); tick();                           // cycle 5
`ifdef ARB_ROUND_ROBIN_EN
    chk("t5_d_gnt", a_d_gnt, 1);
    d_req = 1'b0;
`else
    chk("t5_if_gnt", a_if_gnt, 1);
    chk("t5_mem_addr", a_mem_addr, 32'h44);
    if_req = 1'b0;
`endif

    // Byte store, MEM_LAT=3
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h203; d_wdata = 32'hAB;
    mem_rdata = 32'hDEADBEEF;
    tick();                                   // cycle 1
    chk("w1_mem_en", b_mem_en, 1);
    chk("w1_mem_we", b_mem_we, 1);
    chk("w1_mem_size", b_mem_size, 0);
    chk("w1_mem_addr", b_mem_addr, 32'h203);
    chk("w1_mem_wdata", b_mem_wdata, 32'hAB);
    chk("w1_d_gnt", b_d_gnt, 1);
    d_req = 1'b0; d_we = 1'b0;
    tick();                                   // cycle 2
    chk("w2_mem_we", b_mem_we, 0);
    chk("w2_d_rvalid", b_d_rvalid, 0);
    tick();                                   // cycle 3
    chk("w3_d_rvalid", b_d_rvalid, 0);
    tick();                                   // cycle 4
    chk("w4_d_rvalid", b_d_rvalid, 1);
    chk("w4_d_rdata", b_d_rdata, 0);
    tick();
    chk("w5_busy", b_busy, 0);

    // Halt during WAIT with a fetch pending, MEM_LAT=3
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h300;
    tick();                                   // cycle 1
    chk("h1_d_gnt", b_d_gnt, 1);
    d_req = 1'b0;
    tick();                                   // cycle 2 (WAIT)
    halt = 1'b1; if_req = 1'b1; if_addr = 32'h50; mem_rdata = 32'h77;
    tick(); tick();                           // cycle 4
    chk("h4_d_rvalid", b_d_rvalid, 1);
    chk("h4_d_rdata", b_d_rdata, 32'h77);
    tick();                                   // cycle 5
    chk("h5_mem_en", b_mem_en, 0);
    chk("h5_busy", b_busy, 0);
    tick();                                   // cycle 6
    chk("h6_if_gnt", b_if_gnt, 0);
    halt = 1'b0;
    tick();                                   // cycle 7
    chk("h7_mem_en", b_mem_en, 1);
    chk("h7_if_gnt", b_if_gnt, 1);
    chk("h7_mem_addr", b_mem_addr, 32'h50);
    if_req = 1'b0;

    // Reset one cycle after ISSUE, MEM_LAT=3
    do_reset();
    if_req = 1'b1; if_addr = 32'h60;
    tick();                                   // cycle 1
    chk("r1_if_gnt", b_if_gnt, 1);
    if_req = 1'b0;
    tick();                                   // cycle 2
    rst = 1'b1;
    tick();                                   // cycle 3
    rst = 1'b0;
    chk("r3_busy", b_busy, 0);
    chk("r3_outs", {b_mem_en, b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid}, 0);
    chk("r3_mem_addr", b_mem_addr, 0);
    gnt_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b_if_rvalid) gnt_seen++;
    end
    chk("r_no_rvalid", gnt_seen, 0);

    // Fetch request withdrawn during a data WAIT, MEM_LAT=3
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h400;
    tick();                                   // cycle 1
    d_req = 1'b0;
    tick();                                   // cycle 2
    if_req = 1'b1; if_addr = 32'h70;
    gnt_seen = 0;
    tick();                                   // cycle 3
    if_req = 1'b0;
    if (b_if_gnt) gnt_seen++;
    tick();                                   // cycle 4
    chk("x4_d_rvalid", b_d_rvalid, 1);
    for (int i = 0; i < 6; i++) begin
      if (b_if_gnt) gnt_seen++;
      tick();
    end
    chk("x_no_if_gnt", gnt_seen, 0);
    chk("x_busy", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
